// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the seg_scan_ctrl board I/O stage: active-low segment
// codes, hex decoder and default timing parameters.
package seg_scan_ctrl_pkg;

  localparam logic [15:0] SCAN_DIV_DEF   = 16'd50000;
  localparam logic [19:0] DEB_CYCLES_DEF = 20'd1000000;

  // Segment order {g,f,e,d,c,b,a}, 0 = lit
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  function automatic logic [6:0] hexdec(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Board-side signal bundle between PCPU, the display and the push-button.
interface seg_scan_ctrl_if;
  logic [15:0] y;
  logic        btn_next;
  logic [3:0]  select_y;
  logic [3:0]  an;
  logic [6:0]  seg;

  modport master (output y, btn_next, input select_y, an, seg);
  modport slave  (input y, btn_next, output select_y, an, seg);
endinterface

// File: rtl/seg_scan_ctrl_btn.sv
// Push-button conditioner: 2-flop synchroniser, level debouncer and a
// one-cycle pulse on each accepted rising level.
module btn_debounce
  import seg_scan_ctrl_pkg::*;
#(
  parameter logic [19:0] DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  logic        sync1, synced, stable, prev;
  logic [19:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= 1'b0;
      synced <= 1'b0;
      stable <= 1'b0;
      prev   <= 1'b0;
      count  <= '0;
    end else begin
      sync1  <= raw;
      synced <= sync1;
      prev   <= stable;
      // Any return to the stable level restarts the qualification window
      if (synced == stable) begin
        count <= '0;
      end else if (count == DEB_CYCLES - 20'd1) begin
        stable <= synced;
        count  <= '0;
      end else begin
        count <= count + 20'd1;
      end
    end
  end

  assign rise = stable & ~prev;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Board I/O stage around PCPU: scans y onto a 4-digit common-anode display
// and steps select_y on each debounced button press.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV   = SCAN_DIV_DEF,
  parameter logic [19:0] DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic           clock,
  input  logic           reset,
  seg_scan_ctrl_if.slave io
);

  logic [15:0]     scan_cnt;
  logic [1:0]      digit;
  logic [1:0]      digit_nxt;
  logic            scan_wrap;
  logic            step;
  logic [3:0][3:0] nib;

  assign nib       = io.y;
  assign scan_wrap = (scan_cnt == SCAN_DIV - 16'd1);
  assign digit_nxt = digit + 2'd1;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clock (clock),
    .reset (reset),
    .raw   (io.btn_next),
    .rise  (step)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      scan_cnt    <= '0;
      digit       <= '0;
      io.an       <= AN_OFF;
      io.seg      <= SEG_BLANK;
      io.select_y <= '0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 16'd1;
      // y is sampled only here, once per digit slot
      if (scan_wrap) begin
        digit  <= digit_nxt;
        io.an  <= ~(4'b0001 << digit_nxt);
        io.seg <= hexdec(nib[digit_nxt]);
      end
      if (step) io.select_y <= io.select_y + 4'd1;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scenario bench for seg_scan_ctrl with SCAN_DIV=4, DEB_CYCLES=4.
module tb_seg_scan_ctrl;

  localparam int SD = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  seg_scan_ctrl_if io();

  seg_scan_ctrl #(.SCAN_DIV(16'd4), .DEB_CYCLES(20'd4)) dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Display reference: slot index = edges since reset / SD; slot 0 is blank
  int         n_edge = 0;
  logic [3:0] m_an = 4'b1111;
  logic [6:0] m_seg = 7'b1111111;
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [14:0] sb [$];

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Predict {an,seg,select_y} after the coming edge from the inputs now driven
  task automatic expect_edge(input logic [3:0] sel);
    int d;
    logic [3:0] onehot;
    logic [15:0] yv;
    if (reset) begin
      n_edge = 0;
      m_an = 4'b1111;
      m_seg = 7'b1111111;
    end else begin
      n_edge++;
      if (n_edge % SD == 0) begin
        d = (n_edge / SD) % 4;
        onehot = 4'b0001 << d;
        m_an = ~onehot;
        yv = io.y;
        m_seg = seg_tab[yv[4*d +: 4]];
      end
    end
    sb.push_back({m_an, m_seg, sel});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    io.btn_next = 1'b0;
    n_edge = 0;
    m_an = 4'b1111;
    m_seg = 7'b1111111;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] e, got;
    reset = 1'b1;
    io.btn_next = 1'b1;
    io.y = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      expect_edge(4'd0);
      tick();
      got = {io.an, io.seg, io.select_y};
      e = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %h expected %h", i, got, e);
      end
    end
    io.btn_next = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_scan();
    logic [14:0] e, got;
    do_reset();
    io.y = 16'h8A1F;
    for (int i = 1; i <= 40; i++) begin
      expect_edge(4'd0);
      tick();
      got = {io.an, io.seg, io.select_y};
      e = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL scan edge %0d: got an=%b seg=%b sel=%0d expected an=%b seg=%b sel=%0d",
                 i, got[14:11], got[10:4], got[3:0], e[14:11], e[10:4], e[3:0]);
      end
    end
  endtask

  task automatic test_press();
    logic [14:0] e, got;
    do_reset();
    io.btn_next = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 21) io.btn_next = 1'b0;
      expect_edge((i >= 7) ? 4'd1 : 4'd0);
      tick();
      got = {io.an, io.seg, io.select_y};
      e = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL press edge %0d: got sel=%0d expected sel=%0d (an/seg got %h exp %h)",
                 i, got[3:0], e[3:0], got[14:4], e[14:4]);
      end
    end
  endtask

  task automatic test_bounce();
    logic [14:0] e, got;
    logic [15:0] pat;
    pat = 16'b0000000000110111;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      io.btn_next = pat[i];
      expect_edge(4'd0);
      tick();
      got = {io.an, io.seg, io.select_y};
      e = sb.pop_front();
      vectors++;
      if (got !== e || dut.u_deb.stable !== 1'b0) begin
        miscompares++;
        $display("FAIL bounce edge %0d: got %h stable=%b expected %h stable=0",
                 i, got, dut.u_deb.stable, e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [14:0] e, got;
    logic [3:0] cur;
    do_reset();
    cur = 4'd0;
    for (int p = 0; p < 16; p++) begin
      for (int i = 1; i <= 16; i++) begin
        io.btn_next = (i <= 8);
        if (i == 7) cur = cur + 4'd1;
        expect_edge(cur);
        tick();
        got = {io.an, io.seg, io.select_y};
        e = sb.pop_front();
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL wrap press %0d edge %0d: got sel=%0d expected sel=%0d", p, i, got[3:0], e[3:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] e, got;
    do_reset();
    io.y = 16'hC3D5;
    for (int i = 1; i <= 9; i++) begin
      io.btn_next = (i >= 6);
      expect_edge(4'd0);
      tick();
      got = {io.an, io.seg, io.select_y};
      e = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL midrst pre edge %0d: got %h expected %h", i, got, e);
      end
    end
    vectors++;
    if (dut.digit !== 2'd2 || dut.u_deb.count !== 20'd2) begin
      miscompares++;
      $display("FAIL midrst setup: got digit=%0d count=%0d expected digit=2 count=2",
               dut.digit, dut.u_deb.count);
    end
    reset = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      if (i == 1) reset = 1'b0;
      expect_edge((i >= 7) ? 4'd1 : 4'd0);
      tick();
      got = {io.an, io.seg, io.select_y};
      e = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL midrst post edge %0d: got an=%b seg=%b sel=%0d expected an=%b seg=%b sel=%0d",
                 i, got[14:11], got[10:4], got[3:0], e[14:11], e[10:4], e[3:0]);
      end
    end
    io.btn_next = 1'b0;
  endtask

  task automatic test_y_change();
    logic [14:0] e, got;
    do_reset();
    io.y = 16'h0000;
    for (int i = 1; i <= 24; i++) begin
      if (i == 15) io.y = 16'hFFFF;
      expect_edge(4'd0);
      tick();
      got = {io.an, io.seg, io.select_y};
      e = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL ychange edge %0d: got an=%b seg=%b expected an=%b seg=%b",
                 i, got[14:11], got[10:4], e[14:11], e[10:4]);
      end
      if (i == 15 || i == 16) begin
        vectors++;
        if (io.seg !== ((i == 15) ? 7'b1000000 : 7'b0001110)) begin
          miscompares++;
          $display("FAIL ychange slot edge %0d: got seg=%b", i, io.seg);
        end
      end
    end
  endtask

  initial begin
    io.y = 16'h0000;
    io.btn_next = 1'b0;
    @(negedge clock);
    test_reset();
    test_scan();
    test_press();
    test_bounce();
    test_wrap();
    test_reset_mid();
    test_y_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Board-side I/O stage wrapped around PCPU.
- Downstream, it consumes the CPU debug word `y` and time-multiplexes it as four hex digits on a common-anode 7-segment display.
- Upstream, it debounces a push-button and advances the CPU's `select_y` index, wrapping modulo 16.
- Everything runs in the CPU clock domain.

Parameters:
- SCAN_DIV, 16'd50000, clock cycles each digit stays lit (>=2).
- DEB_CYCLES, 20'd1000000, consecutive stable cycles required before a button level change is accepted (>=2).

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- y  input  16  CPU debug output word; digit k shows y[4k+3:4k].
- btn_next  input  1  raw push-button, active-high, asynchronous, may bounce.
- select_y  output  4  registered index driven to PCPU `select_y`.
- an  output  4  registered digit enables, active-low; an[0] is the rightmost digit.
- seg  output  7  registered segments, active-low, ordered {g,f,e,d,c,b,a}.

Behaviour:
- Reset values (clock edge with reset=1):
  - select_y=0, an=4'b1111, seg=7'b1111111.
  - scan_cnt=0, digit=0.
  - Sync flops, stable level, previous level and debounce count all 0.
- Reset wins over every other event in the same cycle. Reset mid-scan or mid-debounce discards all progress.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - On each edge where scan_cnt==SCAN_DIV-1:
    - digit <= (digit+1) mod 4.
    - an <= one-cold of the new digit.
    - seg <= hexdec(y nibble selected by the new digit).
  - y is therefore sampled exactly once per digit period. Changes to y between samples are not shown until that digit's next slot.
  - Order after reset: the first update lights digit 1, then 2, 3, 0, 1, ...
  - an and seg change only on these edges.
- hexdec table (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Debouncer:
  - Two-flop synchroniser on btn_next produces `synced`.
  - If synced==stable: count<=0.
  - Else if count==DEB_CYCLES-1: stable<=synced, count<=0.
  - Else: count<=count+1.
  - Any bounce back to the stable level restarts the count. Pulses shorter than DEB_CYCLES cycles have no effect.
- Step pulse:
  - prev<=stable each cycle; step = stable & ~prev (one cycle wide).
  - On step: select_y <= select_y+1, with 15 wrapping to 0.
  - A held press gives exactly one increment. Release never increments.
- Latency: for a clean press, select_y changes on the (DEB_CYCLES+3)th rising edge, counting the edge that first samples btn_next=1 as edge 1.
- Scan and debounce paths are independent; simultaneous events do not interact.

Decomposition:
- Shared header:
  - Active-low segment constants SEG_0..SEG_F and SEG_BLANK.
  - An `hexdec` function.
  - Default SCAN_DIV and DEB_CYCLES values.
- One sub-module, `btn_debounce`:
  - Parameter DEB_CYCLES.
  - Ports: clock, reset, raw in, one-cycle rise pulse out.
  - Holds the synchroniser, counter, stable and prev flops.
  - Instantiated once; reusable for future buttons.
- Top level holds the scan counter, digit register, an/seg registers and the select_y counter.

Test Plan (bench uses SCAN_DIV=4, DEB_CYCLES=4):
- Reset then y=16'h8A1F, no button:
  - an=1111, seg=1111111 for 4 edges.
  - Then the sequence an=1101/seg=1111001 ("1"), an=1011/seg=0001000 ("A"), an=0111/seg=0000000 ("8"), an=1110/seg=0001110 ("F"), each held 4 edges, repeating.
- Clean press, btn_next=1 held 20 edges:
  - select_y goes 0->1 on edge 7 and stays 1.
  - Release for 20 edges: select_y stays 1.
- Bounce: btn_next high 3 edges, low 1, high 2, low 10:
  - select_y stays 0.
  - stable never rises.
- Wrap: 16 clean press/release pairs:
  - select_y steps 1..15 then 0.
- Reset mid-operation: assert reset while digit=2 and debounce count=2:
  - Next edge gives an=1111, seg=1111111, select_y=0.
  - Button held through reset needs a full DEB_CYCLES+3 edges after reset release to increment.
- y change between digit slots: set y=16'h0000, then change to 16'hFFFF two edges before digit 0's update:
  - digit 0 shows seg=0001110 ("F").
  - Previously lit digits keep "0" until their next slot.
